// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the IF/DM unified memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int unsigned WORD_OFFSET_BITS = 2;
  localparam int unsigned CONFLICT_CNT_W   = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

endpackage

// File: rtl/unified_mem_arbiter_starve_guard.sv
// Saturating count of consecutive denied fetch cycles; force_if gives IF the next conflict.
module unified_mem_arbiter_starve_guard #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic denied,
  input  logic clear,
  output logic force_if
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear) begin
      cnt_nxt = '0;
    end else if (denied && (cnt != CNT_W'(STARVE_MAX))) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // force_if is registered alongside the count so it is ready at the start of the cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      force_if <= (STARVE_MAX == 0);
    end else begin
      cnt      <= cnt_nxt;
      force_if <= (cnt_nxt == CNT_W'(STARVE_MAX));
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// One-access-per-cycle arbiter between fetch and data ports of a single-ported unified memory.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               if_req,
  input  logic [ADDR_W-1:0]                  if_addr,
  output logic                               if_gnt,
  output logic                               if_rvalid,
  output logic [DATA_W-1:0]                  if_rdata,
  output logic                               if_err,
  input  logic                               dm_req,
  input  logic                               dm_we,
  input  logic [ADDR_W-1:0]                  dm_addr,
  input  logic [DATA_W-1:0]                  dm_wdata,
  output logic                               dm_gnt,
  output logic                               dm_rvalid,
  output logic [DATA_W-1:0]                  dm_rdata,
  output logic                               dm_err,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [ADDR_W-WORD_OFFSET_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output logic [CONFLICT_CNT_W-1:0]          conflict_cnt
);

  logic   if_aligned, if_misaligned;
  logic   dm_aligned, dm_misaligned;
  logic   force_if;
  logic   win_if, win_dm;
  logic   if_denied, if_clear;
  owner_e owner, owner_nxt;

  assign if_aligned    = if_req && (if_addr[WORD_OFFSET_BITS-1:0] == '0);
  assign if_misaligned = if_req && (if_addr[WORD_OFFSET_BITS-1:0] != '0);
  assign dm_aligned    = dm_req && (dm_addr[WORD_OFFSET_BITS-1:0] == '0);
  assign dm_misaligned = dm_req && (dm_addr[WORD_OFFSET_BITS-1:0] != '0);

  // DM owns the memory on a conflict unless fetch has been starved long enough
  assign win_if = if_aligned && (!dm_aligned || force_if);
  assign win_dm = dm_aligned && !win_if;

  assign if_denied = if_aligned && !win_if;
  assign if_clear  = !if_req || win_if || if_misaligned;

  unified_mem_arbiter_starve_guard #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_guard (
    .clk      (clk),
    .reset    (reset),
    .denied   (if_denied),
    .clear    (if_clear),
    .force_if (force_if)
  );

  // Misaligned requests are consumed without touching memory
  assign if_gnt    = !reset && (win_if || if_misaligned);
  assign dm_gnt    = !reset && (win_dm || dm_misaligned);
  assign mem_en    = !reset && (win_if || win_dm);
  assign mem_we    = !reset && win_dm && dm_we;
  assign mem_addr  = win_dm ? dm_addr[ADDR_W-1:WORD_OFFSET_BITS]
                            : if_addr[ADDR_W-1:WORD_OFFSET_BITS];
  assign mem_wdata = dm_wdata;

  always_comb begin
    owner_nxt = OWN_NONE;
    if (win_if) begin
      owner_nxt = OWN_IF;
    end else if (win_dm && !dm_we) begin
      owner_nxt = OWN_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= OWN_NONE;
      if_err       <= 1'b0;
      dm_err       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      owner  <= owner_nxt;
      if_err <= if_misaligned;
      dm_err <= dm_misaligned;
      if (if_aligned && dm_aligned && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CONFLICT_CNT_W'(1);
      end
    end
  end

  // Read data is steered to whichever port owned last cycle's read
  assign if_rvalid = (owner == OWN_IF);
  assign dm_rvalid = (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus random bench for unified_mem_arbiter against a behavioural arbitration model.
module tb_unified_mem_arbiter;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned WORDS      = 64;

  logic                clk;
  logic                reset;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_gnt, if_rvalid, if_err;
  logic [DATA_W-1:0]   if_rdata;
  logic                dm_req, dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic                dm_gnt, dm_rvalid, dm_err;
  logic [DATA_W-1:0]   dm_rdata;
  logic                mem_en, mem_we;
  logic [ADDR_W-3:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic [15:0]         conflict_cnt;

  unified_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .dm_err       (dm_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // Single-ported synchronous memory attached to the arbiter
  logic [DATA_W-1:0] mem [WORDS];
  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] <= init_word(i);
    mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  // Reference model state
  logic [31:0] shadow [WORDS];
  int          m_starve, m_conf;
  logic        exp_if_rv, exp_dm_rv, exp_if_err, exp_dm_err;
  logic [31:0] exp_if_rd, exp_dm_rd;
  logic        g_if, g_dm;
  int          n_assert, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: check registered outputs, predict and check grants, advance the model
  task automatic step();
    bit ia, im, da, dmis, wi, wd, e_en;
    int e_addr;
    @(negedge clk);
    chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
    chk("if_rdata", if_rdata, exp_if_rv ? exp_if_rd : 32'h0);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm_rv));
    chk("dm_rdata", dm_rdata, exp_dm_rv ? exp_dm_rd : 32'h0);
    chk("if_err", 32'(if_err), 32'(exp_if_err));
    chk("dm_err", 32'(dm_err), 32'(exp_dm_err));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

    ia   = if_req && (int'(if_addr) % 4 == 0);
    im   = if_req && (int'(if_addr) % 4 != 0);
    da   = dm_req && (int'(dm_addr) % 4 == 0);
    dmis = dm_req && (int'(dm_addr) % 4 != 0);
    wi   = ia && (!da || m_starve == int'(STARVE_MAX));
    wd   = da && !wi;
    e_en = !reset && (wi || wd);
    g_if = !reset && (wi || im);
    g_dm = !reset && (wd || dmis);
    e_addr = wd ? int'(dm_addr) / 4 : int'(if_addr) / 4;

    chk("if_gnt", 32'(if_gnt), 32'(g_if));
    chk("dm_gnt", 32'(dm_gnt), 32'(g_dm));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      chk("mem_we", 32'(mem_we), 32'(wd && dm_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (wd && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
    end

    if (reset) begin
      exp_if_rv = 0; exp_dm_rv = 0; exp_if_err = 0; exp_dm_err = 0;
      m_starve = 0; m_conf = 0;
    end else begin
      exp_if_rv  = wi;
      exp_if_rd  = shadow[int'(if_addr) / 4];
      exp_dm_rv  = wd && !dm_we;
      exp_dm_rd  = shadow[int'(dm_addr) / 4];
      exp_if_err = im;
      exp_dm_err = dmis;
      if (wd && dm_we) shadow[int'(dm_addr) / 4] = dm_wdata;
      if (ia && da && m_conf < 65535) m_conf++;
      if (ia && !wi) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : m_starve;
      else           m_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_addr();
    int a;
    a = int'($urandom_range(0, 63)) * 4;
    if ($urandom_range(0, 3) == 0) a += int'($urandom_range(1, 3));
    return 8'(a);
  endfunction

  initial begin
    n_assert = 0; n_fail = 0;
    m_starve = 0; m_conf = 0;
    exp_if_rv = 0; exp_dm_rv = 0; exp_if_err = 0; exp_dm_err = 0;
    exp_if_rd = '0; exp_dm_rd = '0;
    g_if = 0; g_dm = 0;
    for (int i = 0; i < int'(WORDS); i++) shadow[i] = init_word(i);
    reset = 1; if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    reset = 0;
    step();

    // IF only, three fetches of word 1
    if_req = 1; if_addr = 8'h04;
    step(); step(); step();
    chk("tp_if_word1", if_rdata, init_word(1));
    if_req = 0;
    step();

    // Conflict: DM load held, IF wins on the fourth cycle
    if_req = 1; if_addr = 8'h00;
    dm_req = 1; dm_we = 0; dm_addr = 8'h10;
    step(); step(); step();
    chk("tp_if_starved", 32'(if_rvalid), 32'h0);
    step();
    chk("tp_conflict4", 32'(conflict_cnt), 32'd4);
    chk("tp_if_after_starve", 32'(if_rvalid), 32'h1);
    if_req = 0; dm_req = 0;
    step();

    // Store wins over IF, IF granted next cycle, store read back
    if_req = 1; if_addr = 8'h08;
    dm_req = 1; dm_we = 1; dm_addr = 8'h20; dm_wdata = 32'hDEADBEEF;
    step();
    chk("tp_store_no_rvalid", 32'(dm_rvalid), 32'h0);
    dm_req = 0; dm_we = 0;
    step();
    chk("tp_if_after_store", if_rdata, init_word(2));
    if_req = 0;
    dm_req = 1; dm_addr = 8'h20;
    step();
    chk("tp_store_readback", dm_rdata, 32'hDEADBEEF);
    dm_req = 0;
    step();

    // Misaligned DM alongside aligned IF
    if_req = 1; if_addr = 8'h00;
    dm_req = 1; dm_addr = 8'h13;
    step();
    chk("tp_mis_dm_err", 32'(dm_err), 32'h1);
    chk("tp_mis_if_rvalid", 32'(if_rvalid), 32'h1);
    chk("tp_mis_dm_rvalid", 32'(dm_rvalid), 32'h0);
    dm_req = 0;
    step();

    // Reset right after an IF grant drops the read
    reset = 1; if_req = 0;
    step();
    chk("tp_reset_rvalid", 32'(if_rvalid), 32'h0);
    chk("tp_reset_conflict", 32'(conflict_cnt), 32'h0);
    reset = 0;
    step();

    // Randomised traffic with requesters holding until granted
    for (int n = 0; n < 2000; n++) begin
      if (!if_req || g_if) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
      if (!dm_req || g_dm) begin
        dm_req = ($urandom_range(0, 3) != 0);
        dm_we = $urandom_range(0, 1) == 1;
        dm_addr = rand_addr();
        dm_wdata = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0;

    // Long conflict run to saturate the counter
    if_req = 1; if_addr = 8'h04;
    dm_req = 1; dm_we = 0; dm_addr = 8'h08;
    for (int n = 0; n < 65540; n++) step();
    chk("tp_conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
    if_req = 0; dm_req = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
